oscillator: RTL and testbench

- Phase-accumulator (NCO) audio oscillator, one instance per voice in the audio block.
- Clocked by the sample-rate strobe clock (the system clock divided by 256, about 31.25 kHz from 8 MHz).
- Each sample clock adds a tuning word to a fractional phase accumulator.
- The upper phase bits are waveshaped into an unsigned BITDEPTH-bit sample.

---
 rtl/osc_pkg.sv | 17 +
 rtl/osc_waveshaper.sv | 35 +++
 rtl/oscillator.sv | 75 +++++++
 tb/tb_oscillator.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared constants for the phase-accumulator voice oscillators.
`timescale 1ns/1ps
`default_nettype none

package osc_pkg;

  localparam int WAVE_SAW      = 0;
  localparam int WAVE_SQUARE   = 1;
  localparam int WAVE_TRIANGLE = 2;

  localparam int DEF_BITDEPTH    = 12;
  localparam int DEF_BITFRACTION = 12;
  localparam int DEF_INCWIDTH    = 19;

endpackage

`default_nettype wire

// File: rtl/osc_waveshaper.sv
// Combinational map from an accumulator phase word to an unsigned sample
// (saw, square or triangle); shared by every voice type.
`timescale 1ns/1ps
`default_nettype none

module osc_waveshaper
  import osc_pkg::*;
#(
  parameter int BITDEPTH    = DEF_BITDEPTH,
  parameter int BITFRACTION = DEF_BITFRACTION,
  parameter int WAVEFORM    = WAVE_SAW
) (
  input  logic [BITDEPTH+BITFRACTION-1:0] phase_i,
  output logic [BITDEPTH-1:0]             out_o
);

  localparam int ACCW = BITDEPTH + BITFRACTION;

  // Each shape reads only part of the phase word.
  logic unused_phase;
  assign unused_phase = ^phase_i;

  if (WAVEFORM == WAVE_SQUARE) begin : g_square
    assign out_o = {BITDEPTH{phase_i[ACCW-1]}};
  end else if (WAVEFORM == WAVE_TRIANGLE) begin : g_triangle
    logic [BITDEPTH-1:0] tri_half;
    assign tri_half = phase_i[ACCW-2 -: BITDEPTH];
    assign out_o    = phase_i[ACCW-1] ? ~tri_half : tri_half;
  end else begin : g_saw
    assign out_o = phase_i[ACCW-1 -: BITDEPTH];
  end

endmodule

`default_nettype wire

// File: rtl/oscillator.sv
// NCO audio voice: phase accumulator clocked by the sample strobe, waveshaped output.
// Optional OSC_WRAP_FLAG_EN adds a one-sample 'wrap' pulse on accumulator overflow.
`timescale 1ns/1ps
`default_nettype none

module oscillator
  import osc_pkg::*;
#(
  parameter int BITDEPTH    = DEF_BITDEPTH,
  parameter int BITFRACTION = DEF_BITFRACTION,
  parameter int INCWIDTH    = DEF_INCWIDTH,
  parameter int WAVEFORM    = WAVE_SAW
) (
  input  logic                sample_clock,
  input  logic                rst_n,
  input  logic [INCWIDTH-1:0] increment,
  output logic [BITDEPTH-1:0] out
`ifdef OSC_WRAP_FLAG_EN
  ,
  output logic                wrap
`endif
);

  localparam int ACCW = BITDEPTH + BITFRACTION;

  if (INCWIDTH > ACCW) begin : g_bad_incwidth
    $error("oscillator: INCWIDTH must not exceed BITDEPTH+BITFRACTION");
  end

  logic [ACCW-1:0] phase_q;
  logic [ACCW-1:0] phase_d;
  logic            carry;

  // Modulo-2^ACCW sum; the carry out marks a period boundary.
  always_comb begin
    {carry, phase_d} = {1'b0, phase_q} + {1'b0, ACCW'(increment)};
  end

  always_ff @(posedge sample_clock or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

`ifdef OSC_WRAP_FLAG_EN
  logic wrap_q;

  always_ff @(posedge sample_clock or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= carry;
    end
  end

  assign wrap = wrap_q;
`else
  logic unused_carry;
  assign unused_carry = carry;
`endif

  osc_waveshaper #(
    .BITDEPTH    (BITDEPTH),
    .BITFRACTION (BITFRACTION),
    .WAVEFORM    (WAVEFORM)
  ) u_shaper (
    .phase_i (phase_q),
    .out_o   (out)
  );

endmodule

`default_nettype wire

// File: tb/tb_oscillator.sv
// Scoreboard bench for oscillator: saw, square and triangle instances share one stimulus.
`timescale 1ns/1ps
`default_nettype none

module tb_oscillator;
  import osc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] inc;
  logic [11:0] o_saw, o_sq, o_tri;
`ifdef OSC_WRAP_FLAG_EN
  logic        w_saw, w_sq, w_tri;
`endif

  always #5 clk = ~clk;

  oscillator #(.WAVEFORM(WAVE_SAW)) u_saw (
    .sample_clock (clk), .rst_n (rst_n), .increment (inc), .out (o_saw)
`ifdef OSC_WRAP_FLAG_EN
    , .wrap (w_saw)
`endif
  );

  oscillator #(.WAVEFORM(WAVE_SQUARE)) u_sq (
    .sample_clock (clk), .rst_n (rst_n), .increment (inc), .out (o_sq)
`ifdef OSC_WRAP_FLAG_EN
    , .wrap (w_sq)
`endif
  );

  oscillator #(.WAVEFORM(WAVE_TRIANGLE)) u_tri (
    .sample_clock (clk), .rst_n (rst_n), .increment (inc), .out (o_tri)
`ifdef OSC_WRAP_FLAG_EN
    , .wrap (w_tri)
`endif
  );

  typedef struct {
    string tag;
    int    n;
    int    saw;
    int    sq;
    int    tv;
    int    wr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input int n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s n=%0d got=%0d want=%0d", tag, n, got, want);
    end
  endtask

  task automatic push(input string tag, input int n, input int saw, input int sq, input int tv, input int wr);
    exp_t e;
    e.tag = tag; e.n = n; e.saw = saw; e.sq = sq; e.tv = tv; e.wr = wr;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_saw"}, 0, 32'(o_saw), 0);
    chk({tag, "_sq"},  0, 32'(o_sq),  0);
    chk({tag, "_tri"}, 0, 32'(o_tri), 0);
`ifdef OSC_WRAP_FLAG_EN
    chk({tag, "_wrap"}, 0, 32'(w_saw), 0);
`endif
  endtask

  // Monitor: one expected entry per rising edge, checked on the following falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_saw"}, e.n, 32'(o_saw), e.saw);
      chk({e.tag, "_sq"},  e.n, 32'(o_sq),  e.sq);
      chk({e.tag, "_tri"}, e.n, 32'(o_tri), e.tv);
`ifdef OSC_WRAP_FLAG_EN
      chk({e.tag, "_wrap"},    e.n, 32'(w_saw), e.wr);
      chk({e.tag, "_wrap_sq"}, e.n, 32'(w_sq),  e.wr);
      chk({e.tag, "_wrap_tr"}, e.n, 32'(w_tri), e.wr);
`endif
    end
  end

  initial begin
    int m, ph, t, msb;
    rst_n = 1'b0;
    inc   = '0;
    #1 chk_zero("rst_init");
    @(negedge clk); #1 rst_n = 1'b1;

    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk); push("hold", n, 0, 0, 0, 0);
    end

    @(negedge clk); #1 inc = 19'd8192;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); push("pre", n, 2 * n, 0, 4 * n, 0);
    end

    // Asynchronous reset mid-count, checked with no clock edge in between.
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk); #1 rst_n = 1'b1;

    for (int n = 1; n <= 2100; n++) begin
      @(posedge clk);
      m = n % 2048;
      push("fast", n, (2 * n) % 4096, (m >= 1024) ? 4095 : 0,
           (m < 1024) ? 4 * m : 4095 - 4 * (m - 1024), (m == 0) ? 1 : 0);
    end

    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk_zero("async_rst2");
    inc = 19'd16;
    @(negedge clk); #1 rst_n = 1'b1;

    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); push("slow", n, n / 256, 0, n / 128, 0);
    end

    @(negedge clk); #1 inc = 19'd8192;
    for (int k = 1; k <= 2060; k++) begin
      @(posedge clk);
      ph  = (300 * 16 + k * 8192) % (1 << 24);
      msb = (ph >> 23) & 1;
      t   = (ph >> 11) & 4095;
      push("retune", k, ph >> 12, msb ? 4095 : 0, msb ? 4095 - t : t, (k == 2048) ? 1 : 0);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) chk("drain", 0, 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
